// File: rtl/mips_div_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
package mips_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } div_state_e;

  localparam int unsigned DIV_CNT_W = 6;

  // Divide-by-zero quotient; sliced to the operand width at the use site.
  localparam logic [63:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the
// shifted partial remainder over WIDTH+1 bits and keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff     = rem_shift - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; result = {rem, quo}.
// Define DIV_SIGNED_EN to build the signed (DIV) path; otherwise all unsigned.
module div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   div_a,
  input  logic [WIDTH-1:0]   div_b,
  input  logic               div_annul,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_ready,
  output logic               div_stall
);

  div_state_e             state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic [2*WIDTH-1:0]     res_q, res_d;
  logic                   rdy_q, rdy_d;
  logic                   stall_c;
  logic                   accept;
  logic [WIDTH-1:0]       abs_a, abs_b;
  logic [WIDTH-1:0]       step_rem, q_fin, fix_q, fix_r;
  logic                   step_q;

  assign accept = (state_q == DIV_IDLE) && div_start && !div_annul;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_shift (({rem_q, quo_q[WIDTH-1]})),
    .divisor   (dvs_q),
    .rem_next  (step_rem),
    .q_bit     (step_q)
  );

  assign q_fin = {quo_q[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d, negr_q, negr_d;

  assign abs_a = (div_signed && div_a[WIDTH-1]) ? -div_a : div_a;
  assign abs_b = (div_signed && div_b[WIDTH-1]) ? -div_b : div_b;
  assign fix_q = negq_q ? -q_fin : q_fin;
  assign fix_r = negr_q ? -step_rem : step_rem;

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (accept) begin
      negq_d = div_signed && (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
      negr_d = div_signed && div_a[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  logic div_signed_unused;

  assign div_signed_unused = div_signed;
  assign abs_a = div_a;
  assign abs_b = div_b;
  assign fix_q = q_fin;
  assign fix_r = step_rem;
`endif

  // Result and ready are loaded on the edge entering END, so the ready pulse
  // and valid result coincide with the END cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    rdy_d   = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          dvs_d   = abs_b;
          if (div_b == '0) begin
            state_d = DIV_BY_ZERO;
            quo_d   = div_a;
          end else begin
            state_d = DIV_ON;
            quo_d   = abs_a;
          end
        end
      end
      DIV_BY_ZERO: begin
        stall_c = 1'b1;
        state_d = DIV_END;
        res_d   = {quo_q, DIV_ZERO_QUO[WIDTH-1:0]};
        rdy_d   = 1'b1;
      end
      DIV_ON: begin
        stall_c = 1'b1;
        rem_d   = step_rem;
        quo_d   = q_fin;
        cnt_d   = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
          state_d = DIV_END;
          res_d   = {fix_r, fix_q};
          rdy_d   = 1'b1;
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    if (div_annul) begin
      state_d = DIV_IDLE;
      res_d   = res_q;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
    end
  end

  assign div_result = res_q;
  assign div_ready  = rdy_q;
  assign div_stall  = stall_c && !rst;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul, back-to-back and reset sequences.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_stall;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_annul  (div_annul),
    .div_result (div_result),
    .div_ready  (div_ready),
    .div_stall  (div_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts a divide in the current cycle (cycle 0) and follows it to div_ready.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [63:0] exp, input int exp_cyc, input string nm);
    logic [63:0] res;
    int stall_n;
    int rdy_cyc;
    res     = '0;
    stall_n = 0;
    rdy_cyc = -1;
    div_a      = a;
    div_b      = b;
    div_signed = sg;
    div_start  = 1'b1;
    for (int c = 0; c < 60 && rdy_cyc < 0; c++) begin
      @(negedge clk);
      if (div_stall) stall_n++;
      if (div_ready) begin
        rdy_cyc   = c;
        res       = div_result;
        div_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    div_start = 1'b0;
    chk({nm, "_ready_cycle"}, 64'(rdy_cyc), 64'(exp_cyc));
    chk({nm, "_stall_cycles"}, 64'(stall_n), 64'(exp_cyc));
    chk({nm, "_result"}, res, exp);
  endtask

  initial begin
    int seen;

    vecs[0] = '{a: 32'd100, b: 32'd7, sg: 1'b0, q: 32'h0000000E, r: 32'h00000002, cyc: 33};
`ifdef DIV_SIGNED_EN
    vecs[1] = '{a: 32'hFFFFFFF9, b: 32'd2, sg: 1'b1, q: 32'hFFFFFFFD, r: 32'hFFFFFFFF, cyc: 33};
    vecs[3] = '{a: 32'h80000000, b: 32'hFFFFFFFF, sg: 1'b1, q: 32'h80000000, r: 32'h0, cyc: 33};
    vecs[6] = '{a: 32'hFFFFFF9C, b: 32'd7, sg: 1'b1, q: 32'hFFFFFFF2, r: 32'hFFFFFFFE, cyc: 33};
    vecs[7] = '{a: 32'd100, b: 32'hFFFFFFF9, sg: 1'b1, q: 32'hFFFFFFF2, r: 32'h00000002, cyc: 33};
`else
    vecs[1] = '{a: 32'hFFFFFFF9, b: 32'd2, sg: 1'b1, q: 32'h7FFFFFFC, r: 32'h00000001, cyc: 33};
    vecs[3] = '{a: 32'h80000000, b: 32'hFFFFFFFF, sg: 1'b1, q: 32'h0, r: 32'h80000000, cyc: 33};
    vecs[6] = '{a: 32'hFFFFFF9C, b: 32'd7, sg: 1'b1, q: 32'h24924916, r: 32'h00000002, cyc: 33};
    vecs[7] = '{a: 32'd100, b: 32'hFFFFFFF9, sg: 1'b1, q: 32'h0, r: 32'h00000064, cyc: 33};
`endif
    vecs[2] = '{a: 32'd5, b: 32'd0, sg: 1'b1, q: 32'hFFFFFFFF, r: 32'h00000005, cyc: 2};
    vecs[4] = '{a: 32'hFFFFFFFF, b: 32'd1, sg: 1'b0, q: 32'hFFFFFFFF, r: 32'h0, cyc: 33};
    vecs[5] = '{a: 32'd7, b: 32'd9, sg: 1'b0, q: 32'h0, r: 32'h00000007, cyc: 33};
    vecs[8] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, sg: 1'b0, q: 32'h1, r: 32'h0, cyc: 33};

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_annul  = 1'b0;

    @(negedge clk);
    chk("reset_stall", 64'(div_stall), 64'd0);
    chk("reset_ready", 64'(div_ready), 64'd0);
    chk("reset_result", div_result, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].sg, {vecs[i].r, vecs[i].q}, vecs[i].cyc,
             $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
      #1;
    end

    // Annul at cycle 10 of 1000/3: no ready, result keeps the last completion.
    seen       = 0;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (div_ready) seen++;
      if (c == 10) div_annul = 1'b1;
      @(posedge clk);
      #1;
    end
    div_annul = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    chk("annul_idle_stall", 64'(div_stall), 64'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (div_ready) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result_held", div_result, 64'h00000000_00000001);
    @(posedge clk);
    #1;

    do_div(32'd20, 32'd4, 1'b0, 64'h00000000_00000005, 33, "b2b_first");
    do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, "b2b_second");
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted at cycle 15 of an in-flight divide.
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_stall", 64'(div_stall), 64'd0);
    chk("midrst_ready", 64'(div_ready), 64'd0);
    chk("midrst_result", div_result, 64'd0);
    div_start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    do_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider for the MIPS `DIV`/`DIVU` instructions.
- Sits in the execute stage beside the ALU.
- Holds the pipeline via a stall request while it iterates.
- Hands a 64-bit {remainder, quotient} result to the HI/LO register write path in the memory stage: HI = remainder, LO = quotient.
- A flush or exception annuls an in-flight divide.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `div_start`  in  1  execute stage holds a divide; held high for as long as that instruction sits in E.
- `div_signed`  in  1  1 = `DIV` (two's complement), 0 = `DIVU`. Sampled only when a divide is accepted.
- `div_a`  in  WIDTH  dividend (rs). Sampled only when a divide is accepted.
- `div_b`  in  WIDTH  divisor (rt). Sampled only when a divide is accepted.
- `div_annul`  in  1  flush/exception; cancels the current operation.
- `div_result`  out  2*WIDTH  {remainder, quotient}. Reset value 0.
- `div_ready`  out  1  one-cycle pulse; `div_result` is valid in that cycle. Reset value 0.
- `div_stall`  out  1  stall request to hazard unit. Reset value 0.

## Operation
States: IDLE, BY_ZERO, ON, END.
- **IDLE**
  - `div_start` = 1, `div_annul` = 0, `div_b` = 0 → BY_ZERO.
  - `div_start` = 1, `div_annul` = 0, `div_b` ≠ 0 → ON. Latch `div_signed`. Latch |a| and |b| (absolute values when signed, raw values otherwise). Clear the 6-bit iteration counter.
- **BY_ZERO** → END. Loads quotient = all ones and remainder = `div_a` as latched.
- **ON** performs one restoring step per cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor over WIDTH+1 bits.
  - If the difference is non-negative, keep it and set quotient bit 1; otherwise restore and set the bit to 0.
  - Increment the counter. After WIDTH steps → END.
- **END**
  - Apply sign fix-up when signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Register `div_result` and pulse `div_ready`.
  - Unconditionally return to IDLE.
- **Stall output:** `div_stall` = (IDLE && `div_start` && !`div_annul`) || BY_ZERO || ON. It is combinational, and it is 0 in END so the pipeline advances in the ready cycle.
- **Annul:** `div_annul` has priority over everything. In any state it forces IDLE on the next edge. `div_ready` stays 0 and `div_result` keeps its previous value.
- **Back-to-back divides:** if `div_start` is high in the IDLE cycle following END, a new divide is accepted. No dead cycle beyond that IDLE cycle.
- **Signed overflow:** -2^(WIDTH-1) / -1 gives quotient 0x80000000 (wraps) and remainder 0. No trap.
- **Reset mid-operation:** immediately IDLE. All outputs return to 0 and the counter clears.

## Timing
- Acceptance edge = cycle 0.
- Nonzero divisor: `div_stall` is high in cycles 0..32 (33 cycles); `div_ready` is high in cycle 33 (WIDTH+1 after acceptance).
- Zero divisor: `div_stall` is high in cycles 0..1; `div_ready` is high in cycle 2.
- `div_result` is registered. It is valid from the `div_ready` cycle and holds until the next completion, annul has no effect on it, and only reset clears it.
- No combinational path from the operand inputs to any output.

## Configuration
- `DIV_SIGNED_EN` defined:
  - Signed path built: absolute-value input stage and END sign fix-up.
  - `div_signed` selects `DIV` or `DIVU`.
- `DIV_SIGNED_EN` undefined:
  - Those circuits are removed and `div_signed` is ignored.
  - All operations are unsigned. Cycle timing is identical.

## Structure
- Shared package `mips_div_pkg`:
  - state enum `DIV_IDLE`, `DIV_BY_ZERO`, `DIV_ON`, `DIV_END`;
  - `DIV_CNT_W` = 6;
  - localparams for the divide-by-zero quotient (all ones).
- One sub-module: `div_step`. Combinational single restoring iteration.
  - Inputs: partial remainder, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside the ON datapath.

## Test plan
- **Unsigned:** `DIVU` 100 / 7 → `div_result` = {0x00000002, 0x0000000E}; `div_stall` high for exactly 33 cycles; `div_ready` pulses once at cycle 33.
- **Signed negative:** `DIV` -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Divide by zero:** `DIV` 5 / 0 → quotient 0xFFFFFFFF, remainder 0x00000005; `div_ready` at cycle 2; `div_stall` high for 2 cycles.
- **Signed overflow:** `DIV` 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **Annul, then back-to-back:**
  - Start 1000 / 3 and assert `div_annul` at cycle 10 → IDLE at cycle 11; no `div_ready`; `div_result` unchanged.
  - Then start `DIVU` 20 / 4 → {0, 5} at cycle 33.
  - Then in the IDLE cycle right after that `div_ready`, start 9 / 3 → accepted that cycle, giving {0, 3}.
- **Reset mid-operation:** assert `rst` at cycle 15 of an ON sequence → `div_stall`, `div_ready` and `div_result` are 0 immediately. A new divide after release completes with normal 33-cycle timing.
